idex_latch: RTL and testbench

- Decode/execute pipeline register sitting directly upstream of the ALU.
- Captures decoded control and register-file read data from the decode stage, forms the final ALU operands, and presents them registered as PortA/PortB/ALUOP at the start of the execute stage.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.
- Carries the write-back and memory control bits forward to the execute/memory stages.

---
 rtl/idex_latch.sv | 148 ++++++++++++++
 tb/tb_idex_latch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/idex_latch.sv
// Decode/execute pipeline register.
// Forms the final ALU operands from the decode-stage read data and immediate
// fields and registers them with the control bits. The hazard unit can stall
// the register (hold) or flush it (load a bubble). A bubble is all-zero,
// which reads as SLL r0, r0, 0 with every side-effect control cleared.
module idex_latch #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned OP_W   = 4
) (
  input  logic              CLK,
  input  logic              nRST,

  // Hazard-unit control
  input  logic              en,
  input  logic              flush,

  // Decode stage
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_aluop,
  input  logic [WORD_W-1:0] id_rdat1,
  input  logic [WORD_W-1:0] id_rdat2,
  input  logic [15:0]       id_imm16,
  input  logic [4:0]        id_shamt,
  input  logic              id_extop,
  input  logic              id_asel,
  input  logic [1:0]        id_bsel,
  input  logic [REG_W-1:0]  id_wsel,
  input  logic              id_regwen,
  input  logic              id_memren,
  input  logic              id_memwen,
  input  logic [WORD_W-1:0] id_pc4,

  // Execute stage
  output logic [WORD_W-1:0] ex_PortA,
  output logic [WORD_W-1:0] ex_PortB,
  output logic [OP_W-1:0]   ex_ALUOP,
  output logic [WORD_W-1:0] ex_storedat,
  output logic [REG_W-1:0]  ex_wsel,
  output logic              ex_regwen,
  output logic              ex_memren,
  output logic              ex_memwen,
  output logic [WORD_W-1:0] ex_pc4,
  output logic              ex_valid
);

  // PortB source selects
  localparam logic [1:0] BSelRdat2 = 2'b00;
  localparam logic [1:0] BSelImm   = 2'b01;
  localparam logic [1:0] BSelShamt = 2'b10;
  localparam logic [1:0] BSelLui   = 2'b11;

  // Everything carried across the stage boundary.
  typedef struct packed {
    logic              valid;
    logic              regwen;
    logic              memren;
    logic              memwen;
    logic [REG_W-1:0]  wsel;
    logic [OP_W-1:0]   aluop;
    logic [WORD_W-1:0] porta;
    logic [WORD_W-1:0] portb;
    logic [WORD_W-1:0] storedat;
    logic [WORD_W-1:0] pc4;
  } stage_t;

  stage_t            formed;
  stage_t            stage_d;
  stage_t            stage_q;

  logic [WORD_W-1:0] imm_sext;
  logic [WORD_W-1:0] imm_zext;
  logic [WORD_W-1:0] imm_ext;
  logic [WORD_W-1:0] shamt_zext;
  logic [WORD_W-1:0] imm_lui;
  logic [WORD_W-1:0] porta_mux;
  logic [WORD_W-1:0] portb_mux;

  // Immediate variants; LUI ignores extop since the low half is always zero.
  always_comb begin
    imm_sext   = {{(WORD_W-16){id_imm16[15]}}, id_imm16};
    imm_zext   = {{(WORD_W-16){1'b0}}, id_imm16};
    imm_ext    = id_extop ? imm_sext : imm_zext;
    shamt_zext = {{(WORD_W-5){1'b0}}, id_shamt};
    imm_lui    = {id_imm16, {(WORD_W-16){1'b0}}};
  end

  // Operand muxes. asel routes rt to PortA so shifts operate on rt by shamt.
  always_comb begin
    porta_mux = id_asel ? id_rdat2 : id_rdat1;
    portb_mux = id_rdat2;
    unique case (id_bsel)
      BSelRdat2: portb_mux = id_rdat2;
      BSelImm:   portb_mux = imm_ext;
      BSelShamt: portb_mux = shamt_zext;
      BSelLui:   portb_mux = imm_lui;
      default:   portb_mux = id_rdat2;
    endcase
  end

  // Assemble the candidate payload for a real instruction.
  always_comb begin
    formed          = '0;
    formed.valid    = 1'b1;
    formed.regwen   = id_regwen;
    formed.memren   = id_memren;
    formed.memwen   = id_memwen;
    formed.wsel     = id_wsel;
    formed.aluop    = id_aluop;
    formed.porta    = porta_mux;
    formed.portb    = portb_mux;
    // Store data is always rt, independent of which operand PortB carries.
    formed.storedat = id_rdat2;
    formed.pc4      = id_pc4;
  end

  // Next-state: flush beats enable; an invalid decode slot enters as a bubble
  // so stray control bits from decode can never cause a side effect.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (en) begin
      stage_d = id_valid ? formed : '0;
    end
  end

  // Stage register with asynchronous clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign ex_PortA    = stage_q.porta;
  assign ex_PortB    = stage_q.portb;
  assign ex_ALUOP    = stage_q.aluop;
  assign ex_storedat = stage_q.storedat;
  assign ex_wsel     = stage_q.wsel;
  assign ex_regwen   = stage_q.regwen;
  assign ex_memren   = stage_q.memren;
  assign ex_memwen   = stage_q.memwen;
  assign ex_pc4      = stage_q.pc4;
  assign ex_valid    = stage_q.valid;

endmodule

// File: tb/tb_idex_latch.sv
// Directed bench for idex_latch. Expected outputs are queued as stimulus is
// driven and popped one edge later for comparison.
module tb_idex_latch;

  localparam logic [3:0] ALU_SLL = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h3;

  typedef struct packed {
    logic        valid;
    logic        regwen;
    logic        memren;
    logic        memwen;
    logic [4:0]  wsel;
    logic [3:0]  aluop;
    logic [31:0] porta;
    logic [31:0] portb;
    logic [31:0] storedat;
    logic [31:0] pc4;
  } obs_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        en, flush, id_valid;
  logic [3:0]  id_aluop;
  logic [31:0] id_rdat1, id_rdat2, id_pc4;
  logic [15:0] id_imm16;
  logic [4:0]  id_shamt, id_wsel;
  logic        id_extop, id_asel;
  logic [1:0]  id_bsel;
  logic        id_regwen, id_memren, id_memwen;

  logic [31:0] ex_PortA, ex_PortB, ex_storedat, ex_pc4;
  logic [3:0]  ex_ALUOP;
  logic [4:0]  ex_wsel;
  logic        ex_regwen, ex_memren, ex_memwen, ex_valid;

  obs_t obs;
  obs_t exp_q[$];
  obs_t zero_e;
  obs_t a_e;
  int   tests = 0;
  int   fails = 0;

  idex_latch dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .en         (en),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_aluop   (id_aluop),
    .id_rdat1   (id_rdat1),
    .id_rdat2   (id_rdat2),
    .id_imm16   (id_imm16),
    .id_shamt   (id_shamt),
    .id_extop   (id_extop),
    .id_asel    (id_asel),
    .id_bsel    (id_bsel),
    .id_wsel    (id_wsel),
    .id_regwen  (id_regwen),
    .id_memren  (id_memren),
    .id_memwen  (id_memwen),
    .id_pc4     (id_pc4),
    .ex_PortA   (ex_PortA),
    .ex_PortB   (ex_PortB),
    .ex_ALUOP   (ex_ALUOP),
    .ex_storedat(ex_storedat),
    .ex_wsel    (ex_wsel),
    .ex_regwen  (ex_regwen),
    .ex_memren  (ex_memren),
    .ex_memwen  (ex_memwen),
    .ex_pc4     (ex_pc4),
    .ex_valid   (ex_valid)
  );

  always #5 CLK = ~CLK;

  assign obs = '{valid: ex_valid, regwen: ex_regwen, memren: ex_memren, memwen: ex_memwen,
                 wsel: ex_wsel, aluop: ex_ALUOP, porta: ex_PortA, portb: ex_PortB,
                 storedat: ex_storedat, pc4: ex_pc4};

  function automatic obs_t mk(logic v, logic rw, logic mr, logic mw, logic [4:0] ws,
                              logic [3:0] op, logic [31:0] pa, logic [31:0] pb,
                              logic [31:0] sd, logic [31:0] pc);
    obs_t e;
    e = '{valid: v, regwen: rw, memren: mr, memwen: mw, wsel: ws, aluop: op,
          porta: pa, portb: pb, storedat: sd, pc4: pc};
    return e;
  endfunction

  task automatic set_id(logic v, logic [3:0] op, logic [31:0] r1, logic [31:0] r2,
                        logic [15:0] imm, logic [4:0] sh, logic ext, logic as,
                        logic [1:0] bs, logic [4:0] ws, logic rw, logic mr, logic mw,
                        logic [31:0] pc);
    id_valid = v;   id_aluop = op;  id_rdat1 = r1;  id_rdat2 = r2;
    id_imm16 = imm; id_shamt = sh;  id_extop = ext; id_asel = as;
    id_bsel = bs;   id_wsel = ws;   id_regwen = rw; id_memren = mr;
    id_memwen = mw; id_pc4 = pc;
  endtask

  task automatic check(string tag, obs_t got, obs_t want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Advance one edge, then compare against the oldest queued expectation.
  task automatic step(string tag);
    obs_t e;
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, got %h want <queued entry>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  initial begin
    zero_e = '0;
    nRST   = 1'b0;
    en     = 1'b1;
    flush  = 1'b0;
    set_id(1'b1, ALU_SUB, 32'h1111_1111, 32'h2222_2222, 16'h1234, 5'd3, 1'b1, 1'b0,
           2'b00, 5'd9, 1'b1, 1'b1, 1'b1, 32'h40);

    // Clock edges under reset must not load anything.
    repeat (2) @(posedge CLK);
    #1;
    check("reset_hold", obs, zero_e);
    nRST = 1'b1;

    // Disabled edge after release: still zero.
    en = 1'b0;
    exp_q.push_back(zero_e);
    step("post_reset_stall");

    // Basic ADD.
    en = 1'b1;
    set_id(1'b1, ALU_ADD, 32'h5, 32'h3, 16'h0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd7, 1'b1,
           1'b0, 1'b0, 32'h104);
    check("pre_edge_zero", obs, zero_e);
    exp_q.push_back(mk(1, 1, 0, 0, 5'd7, ALU_ADD, 32'h5, 32'h3, 32'h3, 32'h104));
    step("add");

    // Immediate forms.
    set_id(1'b1, ALU_ADD, 32'h10, 32'hAA, 16'hFFF0, 5'd0, 1'b1, 1'b0, 2'b01, 5'd8, 1'b1,
           1'b0, 1'b0, 32'h108);
    exp_q.push_back(mk(1, 1, 0, 0, 5'd8, ALU_ADD, 32'h10, 32'hFFFF_FFF0, 32'hAA, 32'h108));
    step("imm_sext");
    id_extop = 1'b0;
    exp_q.push_back(mk(1, 1, 0, 0, 5'd8, ALU_ADD, 32'h10, 32'h0000_FFF0, 32'hAA, 32'h108));
    step("imm_zext");
    id_extop = 1'b1;
    id_bsel  = 2'b11;
    exp_q.push_back(mk(1, 1, 0, 0, 5'd8, ALU_ADD, 32'h10, 32'hFFF0_0000, 32'hAA, 32'h108));
    step("lui");

    // SLL: rt on PortA, shamt on PortB.
    set_id(1'b1, ALU_SLL, 32'hDEAD, 32'h1, 16'h0, 5'd4, 1'b0, 1'b1, 2'b10, 5'd3, 1'b1,
           1'b0, 1'b0, 32'h10C);
    exp_q.push_back(mk(1, 1, 0, 0, 5'd3, ALU_SLL, 32'h1, 32'h4, 32'h1, 32'h10C));
    step("sll");

    // Stall: A held for three edges, then B issued exactly once.
    set_id(1'b1, ALU_ADD, 32'hA1, 32'hA2, 16'h0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd10, 1'b1,
           1'b0, 1'b0, 32'h200);
    a_e = mk(1, 1, 0, 0, 5'd10, ALU_ADD, 32'hA1, 32'hA2, 32'hA2, 32'h200);
    exp_q.push_back(a_e);
    step("stall_load_a");
    en = 1'b0;
    set_id(1'b1, ALU_SUB, 32'hB1, 32'hB2, 16'h0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd11, 1'b0,
           1'b1, 1'b0, 32'h204);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(a_e);
      step($sformatf("stall_hold_%0d", i));
    end
    en = 1'b1;
    exp_q.push_back(mk(1, 0, 1, 0, 5'd11, ALU_SUB, 32'hB1, 32'hB2, 32'hB2, 32'h204));
    step("stall_release_b");
    id_valid = 1'b0;
    exp_q.push_back(zero_e);
    step("invalid_bubble");

    // Flush while stalled on a store: bubble regardless of en.
    set_id(1'b1, ALU_ADD, 32'hC1, 32'hC2, 16'h4, 5'd0, 1'b1, 1'b0, 2'b01, 5'd0, 1'b0,
           1'b0, 1'b1, 32'h300);
    exp_q.push_back(mk(1, 0, 0, 1, 5'd0, ALU_ADD, 32'hC1, 32'h4, 32'hC2, 32'h300));
    step("store_load");
    en = 1'b0;
    exp_q.push_back(mk(1, 0, 0, 1, 5'd0, ALU_ADD, 32'hC1, 32'h4, 32'hC2, 32'h300));
    step("store_hold");
    flush = 1'b1;
    exp_q.push_back(zero_e);
    step("flush_stalled");
    en = 1'b1;
    set_id(1'b1, ALU_ADD, 32'hD1, 32'hD2, 16'h0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd12, 1'b1,
           1'b1, 1'b1, 32'h400);
    exp_q.push_back(zero_e);
    step("flush_enabled");
    flush = 1'b0;

    // Invalid slot with live-looking controls must still be a bubble.
    id_valid = 1'b0;
    exp_q.push_back(zero_e);
    step("invalid_ctrl_forced");

    // Async reset between edges with valid data loaded.
    id_valid = 1'b1;
    exp_q.push_back(mk(1, 1, 1, 1, 5'd12, ALU_ADD, 32'hD1, 32'hD2, 32'hD2, 32'h400));
    step("pre_async_load");
    #2 nRST = 1'b0;
    #1 check("async_reset", obs, zero_e);
    #1 nRST = 1'b1;
    en = 1'b0;
    exp_q.push_back(zero_e);
    step("after_async_stall");

    check("scoreboard_drained", obs_t'(exp_q.size()), zero_e);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
